ccat_buf: RTL and testbench

- Buffered join (concatenation) stage, the downstream partner of the broadcast block.
- Collects one transfer from each of SIZE independent valid/ready input channels into per-channel one-entry slots.
- Once every slot is filled, presents the slots as a single concatenated output transfer.
- Re-merges broadcast branches after per-branch processing. Branches may complete in different cycles without stalling each other.

---
 rtl/ccat_slot.sv | 50 +++++
 rtl/ccat_buf.sv | 57 +++++
 tb/tb_ccat_buf.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ccat_slot.sv
// ccat_slot: one-entry valid/data holding register for a single join channel.
// A load captures new data and marks the slot full; a clear empties it.
// When both happen in the same cycle the load wins so back-to-back
// transfers keep the slot occupied.
module ccat_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    logic             full_d;
    logic             full_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state for the slot: load has priority over clear, otherwise hold
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = din;
        end else if (clear) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Slot state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= {WIDTH{1'b0}};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/ccat_buf.sv
// ccat_buf: buffered join stage. Each of SIZE valid/ready channels parks one
// transfer in its own slot; once all slots are full the concatenation of the
// slots is offered downstream. Output data comes straight from the slot
// registers, so there is no combinational path from din_data to dout_data.
// The dout_ready -> din_ready path is deliberate: it lets every slot be
// refilled in the same cycle it drains, giving one transfer per cycle.
module ccat_buf #(
    parameter int SIZE  = 2,
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE-1:0]       din_valid,
    output logic [SIZE-1:0]       din_ready,
    input  logic [SIZE*WIDTH-1:0] din_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [SIZE*WIDTH-1:0] dout_data
);

    localparam int DW = SIZE * WIDTH;

    logic [SIZE-1:0] full_s;
    logic [SIZE-1:0] load_s;
    logic [DW-1:0]   slot_data_s;
    logic            fire_s;

    // Join logic: output is valid only when every slot holds a transfer;
    // a slot accepts when empty or when it is being drained this cycle.
    // din_ready never looks at din_valid, so there is no valid->ready loop.
    always_comb begin
        dout_valid = &full_s;
        fire_s     = dout_valid & dout_ready;
        din_ready  = ~full_s | {SIZE{fire_s}};
        load_s     = din_valid & din_ready;
    end

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_slot
            ccat_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk   (clk),
                .rst   (rst),
                .load  (load_s[gi]),
                .clear (fire_s),
                .din   (din_data[gi*WIDTH +: WIDTH]),
                .full  (full_s[gi]),
                .dout  (slot_data_s[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign dout_data = slot_data_s;

endmodule

// File: tb/tb_ccat_buf.sv
// tb_ccat_buf: directed and random checks of the buffered join stage.
// dut2 (SIZE=2, WIDTH=16) takes the directed steps; dut3 (SIZE=3, WIDTH=8)
// runs against a queue model with random valid/ready.
module tb_ccat_buf;

    logic        clk;
    logic        rst;

    logic [1:0]  v2;
    logic [1:0]  r2;
    logic [31:0] d2;
    logic        ov2;
    logic        or2;
    logic [31:0] od2;

    logic [2:0]  v3;
    logic [2:0]  r3;
    logic [23:0] d3;
    logic        ov3;
    logic        or3;
    logic [23:0] od3;

    int n_cmp;
    int n_bad;

    logic [31:0] exp_q[$];
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];

    logic [2:0]  pv;
    logic [23:0] pd;
    logic [2:0]  m_full;
    logic [2:0]  m_rdy;
    logic        m_fire;

    ccat_buf #(.SIZE(2), .WIDTH(16)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (v2),
        .din_ready  (r2),
        .din_data   (d2),
        .dout_valid (ov2),
        .dout_ready (or2),
        .dout_data  (od2)
    );

    ccat_buf #(.SIZE(3), .WIDTH(8)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (v3),
        .din_ready  (r3),
        .din_data   (d3),
        .dout_valid (ov3),
        .dout_ready (or3),
        .dout_data  (od3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        v2 = 2'b00; d2 = 32'h0; or2 = 1'b0;
        v3 = 3'b000; d3 = 24'h0; or3 = 1'b0;
        pv = 3'b000; pd = 24'h0;

        // ---- 1: reset state, and reset holding off captures ----
        tick(); tick();
        #1;
        check("rst_dout_valid", 64'(ov2), 64'(1'b0));
        check("rst_din_ready", 64'(r2), 64'(2'b11));
        check("rst_dout_data", 64'(od2), 64'(32'h0));
        check("rst_din_ready3", 64'(r3), 64'(3'b111));
        for (int c = 0; c < 3; c++) begin
            tick();
            v2 = 2'b11; d2 = 32'h9999_8888;
            #1;
            check("rst_hold_valid", 64'(ov2), 64'(1'b0));
        end
        tick();
        rst = 1'b1; v2 = 2'b00; d2 = 32'h0;
        #1;
        check("post_rst_valid", 64'(ov2), 64'(1'b0));
        check("post_rst_ready", 64'(r2), 64'(2'b11));
        check("post_rst_data", 64'(od2), 64'(32'h0));

        // ---- 2: channels arriving in different cycles ----
        or2 = 1'b1;
        tick();
        v2 = 2'b01; d2 = {16'h0000, 16'h1111};
        #1;
        check("t2_c1_ready", 64'(r2), 64'(2'b11));
        for (int c = 2; c <= 3; c++) begin
            tick();
            v2 = 2'b00;
            #1;
            check("t2_park_ready", 64'(r2), 64'(2'b10));
            check("t2_park_valid", 64'(ov2), 64'(1'b0));
        end
        tick();
        v2 = 2'b10; d2 = {16'h2222, 16'h0000};
        exp_q.push_back(32'h2222_1111);
        #1;
        check("t2_c4_ready", 64'(r2), 64'(2'b10));
        check("t2_c4_valid", 64'(ov2), 64'(1'b0));
        tick();
        v2 = 2'b00;
        #1;
        check("t2_out_valid", 64'(ov2), 64'(1'b1));
        check("t2_out_data", 64'(od2), 64'(exp_q.pop_front()));
        tick();
        #1;
        check("t2_empty_valid", 64'(ov2), 64'(1'b0));
        check("t2_empty_ready", 64'(r2), 64'(2'b11));

        // ---- 3: full-throughput streaming ----
        for (int k = 0; k < 8; k++) begin
            tick();
            v2 = 2'b11;
            d2 = {16'(k + 256), 16'(k)};
            exp_q.push_back({16'(k + 256), 16'(k)});
            #1;
            check("t3_ready", 64'(r2), 64'(2'b11));
            if (k > 0) begin
                check("t3_valid", 64'(ov2), 64'(1'b1));
                check("t3_data", 64'(od2), 64'(exp_q.pop_front()));
            end
        end
        tick();
        v2 = 2'b00;
        #1;
        check("t3_last_valid", 64'(ov2), 64'(1'b1));
        check("t3_last_data", 64'(od2), 64'(exp_q.pop_front()));
        tick();
        #1;
        check("t3_drained", 64'(ov2), 64'(1'b0));

        // ---- 4: output stall ----
        tick();
        or2 = 1'b0; v2 = 2'b11; d2 = 32'h4444_3333;
        exp_q.push_back(32'h4444_3333);
        #1;
        check("t4_fill_ready", 64'(r2), 64'(2'b11));
        for (int c = 0; c < 5; c++) begin
            tick();
            v2 = 2'b11; d2 = 32'h6666_5555;
            #1;
            check("t4_stall_valid", 64'(ov2), 64'(1'b1));
            check("t4_stall_ready", 64'(r2), 64'(2'b00));
            check("t4_stall_data", 64'(od2), 64'(exp_q[0]));
        end
        tick();
        v2 = 2'b00; or2 = 1'b1;
        #1;
        check("t4_rel_valid", 64'(ov2), 64'(1'b1));
        check("t4_rel_data", 64'(od2), 64'(exp_q.pop_front()));
        tick();
        #1;
        check("t4_one_only", 64'(ov2), 64'(1'b0));

        // ---- 5: reset discards a partial collection ----
        tick();
        v2 = 2'b01; d2 = {16'h0000, 16'h7777};
        #1;
        check("t5_fill_ready", 64'(r2), 64'(2'b11));
        tick();
        v2 = 2'b00; rst = 1'b0;
        #1;
        check("t5_partial_ready", 64'(r2), 64'(2'b10));
        tick();
        rst = 1'b1;
        #1;
        check("t5_cleared_ready", 64'(r2), 64'(2'b11));
        check("t5_cleared_valid", 64'(ov2), 64'(1'b0));
        tick();
        v2 = 2'b11; d2 = 32'hBBBB_AAAA;
        exp_q.push_back(32'hBBBB_AAAA);
        #1;
        tick();
        v2 = 2'b00;
        #1;
        check("t5_out_valid", 64'(ov2), 64'(1'b1));
        check("t5_out_data", 64'(od2), 64'(exp_q.pop_front()));
        tick();
        #1;
        check("t5_one_only", 64'(ov2), 64'(1'b0));
        check("t5_queue_empty", 64'(exp_q.size()), 64'(0));

        // ---- 6: random valid/ready on SIZE=3, WIDTH=8 ----
        for (int c = 0; c < 1000; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
                    pv[i] = 1'b1;
                    pd[i*8 +: 8] = 8'($urandom);
                end
            end
            v3 = pv; d3 = pd;
            or3 = 1'($urandom_range(0, 1));
            #1;
            m_full = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
            m_fire = (&m_full) & or3;
            m_rdy  = ~m_full | {3{m_fire}};
            check("rnd_valid", 64'(ov3), 64'(&m_full));
            check("rnd_ready", 64'(r3), 64'(m_rdy));
            if (&m_full) begin
                check("rnd_data", 64'(od3), 64'({q2[0], q1[0], q0[0]}));
            end
            if (m_fire) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
                void'(q2.pop_front());
            end
            if (pv[0] && m_rdy[0]) begin q0.push_back(pd[7:0]);   pv[0] = 1'b0; end
            if (pv[1] && m_rdy[1]) begin q1.push_back(pd[15:8]);  pv[1] = 1'b0; end
            if (pv[2] && m_rdy[2]) begin q2.push_back(pd[23:16]); pv[2] = 1'b0; end
        end
        tick();
        v3 = 3'b000; or3 = 1'b0;
        #1;
        m_full = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
        check("rnd_end_valid", 64'(ov3), 64'(&m_full));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
